// File: rtl/divby_n_detector.sv
// divby_n_detector
// Receive-side monitor for divide-by-N pulse generators. Measures the spacing
// between single-cycle events on pulse_in, reports it as a period, asserts
// locked once the period has repeated LOCK_COUNT times, and flags mismatches
// (err) and missing pulses (timeout). All outputs are registered.

module divby_n_detector #(
  parameter int CNT_W      = 8,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] period,
  output logic             per_valid,
  output logic             locked,
  output logic             err,
  output logic             timeout
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_TRACK = 2'd2;

  // Largest measurable period; the counter stops one short of it so it never wraps.
  localparam logic [CNT_W-1:0] PMAX    = '1;
  localparam logic [CNT_W-1:0] PMAX_M1 = PMAX - CNT_W'(1);
  localparam logic [3:0]       LOCK_MAX = 4'(LOCK_COUNT);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       match_q, match_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             per_valid_q, per_valid_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             timeout_q, timeout_d;

  logic [CNT_W-1:0] meas;
  logic             at_timeout;
  logic [3:0]       match_inc;

  // Measured interval, timeout detection and the saturating match count.
  always_comb begin
    meas       = cnt_q + CNT_W'(1);
    at_timeout = (cnt_q == PMAX_M1) && !pulse_in;
    if (match_q >= LOCK_MAX) begin
      match_inc = LOCK_MAX;
    end else begin
      match_inc = match_q + 4'd1;
    end
  end

  // Next-state logic: disable wins over everything, then event, then timeout.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    match_d     = match_q;
    period_d    = period_q;
    locked_d    = locked_q;
    per_valid_d = 1'b0;
    err_d       = 1'b0;
    timeout_d   = 1'b0;

    if (!en) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      match_d  = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (pulse_in) begin
            state_d = ST_ARMED;
          end
        end

        ST_ARMED: begin
          if (pulse_in) begin
            state_d     = ST_TRACK;
            cnt_d       = '0;
            period_d    = meas;
            per_valid_d = 1'b1;
            match_d     = '0;
          end else if (at_timeout) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_TRACK: begin
          if (pulse_in) begin
            cnt_d       = '0;
            per_valid_d = 1'b1;
            if (meas == period_q) begin
              match_d = match_inc;
              if (match_inc == LOCK_MAX) begin
                locked_d = 1'b1;
              end
            end else begin
              err_d    = 1'b1;
              period_d = meas;
              match_d  = '0;
              locked_d = 1'b0;
            end
          end else if (at_timeout) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            match_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          match_d  = '0;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      match_q     <= '0;
      period_q    <= '0;
      per_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      match_q     <= match_d;
      period_q    <= period_d;
      per_valid_q <= per_valid_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      timeout_q   <= timeout_d;
    end
  end

  assign period    = period_q;
  assign per_valid = per_valid_q;
  assign locked    = locked_q;
  assign err       = err_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_divby_n_detector.sv
// tb_divby_n_detector
// Directed bench for divby_n_detector with a small CNT_W so timeouts are short.
// A timestamp-based model predicts the outputs and is compared every cycle;
// directed literal checks pin the model at the interesting points.

module tb_divby_n_detector;

  localparam int CNT_W      = 4;
  localparam int LOCK_COUNT = 4;
  localparam int PMAX       = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             en;
  logic             pulse_in;
  logic [CNT_W-1:0] period;
  logic             per_valid;
  logic             locked;
  logic             err;
  logic             timeout;

  int checks = 0;
  int errors = 0;

  // Model state: expected outputs plus the timestamp of the last event.
  int now_t      = 0;
  int last_t     = 0;
  bit m_armed    = 0;
  bit m_tracking = 0;
  int m_period   = 0;
  int m_match    = 0;
  bit m_locked   = 0;
  bit m_pv       = 0;
  bit m_err      = 0;
  bit m_to       = 0;

  divby_n_detector #(
    .CNT_W     (CNT_W),
    .LOCK_COUNT(LOCK_COUNT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .pulse_in (pulse_in),
    .period   (period),
    .per_valid(per_valid),
    .locked   (locked),
    .err      (err),
    .timeout  (timeout)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs at a falling edge and return at the next falling edge.
  task automatic applyStimulus(input logic p, input logic e);
    pulse_in = p;
    en       = e;
    @(negedge clk);
  endtask

  // Quiet cycles followed by an event, so the event lands `gap` edges after the previous one.
  task automatic pulseAfter(input int gap);
    for (int i = 1; i < gap; i++) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
  endtask

  // Behavioural model: periods are differences of event timestamps.
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        now_t = 0; last_t = 0; m_armed = 0; m_tracking = 0; m_period = 0;
        m_match = 0; m_locked = 0; m_pv = 0; m_err = 0; m_to = 0;
      end else begin
        now_t++;
        m_pv = 0; m_err = 0; m_to = 0;
        if (!en) begin
          m_armed = 0; m_tracking = 0; m_match = 0; m_locked = 0;
        end else if (pulse_in) begin
          if (!m_armed) begin
            m_armed = 1;
          end else begin
            int gap;
            gap  = now_t - last_t;
            m_pv = 1;
            if (!m_tracking) begin
              m_tracking = 1;
              m_period   = gap;
              m_match    = 0;
            end else if (gap == m_period) begin
              m_match = (m_match + 1 > LOCK_COUNT) ? LOCK_COUNT : m_match + 1;
              if (m_match == LOCK_COUNT) m_locked = 1;
            end else begin
              m_err = 1; m_period = gap; m_match = 0; m_locked = 0;
            end
          end
          last_t = now_t;
        end else if (m_armed && (now_t - last_t == PMAX)) begin
          m_to = 1; m_armed = 0; m_tracking = 0; m_locked = 0; m_match = 0;
        end
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        checkOutput("cmp_period",    int'(period),    m_period);
        checkOutput("cmp_per_valid", int'(per_valid), int'(m_pv));
        checkOutput("cmp_locked",    int'(locked),    int'(m_locked));
        checkOutput("cmp_err",       int'(err),       int'(m_err));
        checkOutput("cmp_timeout",   int'(timeout),   int'(m_to));
      end
    end
  end

  // Divide-by-3 lock sequence: arm, capture, then four matches to lock.
  task automatic lockOnThree(input string tag);
    applyStimulus(1'b1, 1'b1);
    checkOutput({tag, "_arm_pv"}, int'(per_valid), 0);
    pulseAfter(3);
    checkOutput({tag, "_cap_period"}, int'(period), 3);
    checkOutput({tag, "_cap_pv"}, int'(per_valid), 1);
    checkOutput({tag, "_cap_locked"}, int'(locked), 0);
    for (int i = 0; i < 3; i++) pulseAfter(3);
    checkOutput({tag, "_pre_lock"}, int'(locked), 0);
    pulseAfter(3);
    checkOutput({tag, "_locked"}, int'(locked), 1);
    checkOutput({tag, "_err"}, int'(err), 0);
  endtask

  initial begin
    reset    = 1'b1;
    en       = 1'b0;
    pulse_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_period",    int'(period),    0);
    checkOutput("rst_per_valid", int'(per_valid), 0);
    checkOutput("rst_locked",    int'(locked),    0);
    checkOutput("rst_err",       int'(err),       0);
    checkOutput("rst_timeout",   int'(timeout),   0);
    reset = 1'b0;

    lockOnThree("div3");

    // One gap of 5 breaks lock, returning to 3 flags again, then relock.
    pulseAfter(3);
    checkOutput("gap_still_locked", int'(locked), 1);
    pulseAfter(5);
    checkOutput("gap5_err",    int'(err),    1);
    checkOutput("gap5_period", int'(period), 5);
    checkOutput("gap5_locked", int'(locked), 0);
    pulseAfter(3);
    checkOutput("back3_err",    int'(err),    1);
    checkOutput("back3_period", int'(period), 3);
    for (int i = 0; i < 3; i++) pulseAfter(3);
    checkOutput("back3_pre_lock", int'(locked), 0);
    pulseAfter(3);
    checkOutput("back3_relock", int'(locked), 1);

    // en low for one cycle coincident with an event.
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("dis_locked", int'(locked),    0);
    checkOutput("dis_pv",     int'(per_valid), 0);
    checkOutput("dis_err",    int'(err),       0);
    checkOutput("dis_period", int'(period),    3);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("reen_arm_pv", int'(per_valid), 0);
    pulseAfter(4);
    checkOutput("reen_pv",     int'(per_valid), 1);
    checkOutput("reen_period", int'(period),    4);
    checkOutput("reen_err",    int'(err),       0);
    for (int i = 0; i < 4; i++) pulseAfter(4);
    checkOutput("div4_locked", int'(locked), 1);

    // Asynchronous reset mid-count while locked.
    applyStimulus(1'b0, 1'b1);
    #2 reset = 1'b1;
    #1;
    checkOutput("arst_period",    int'(period),    0);
    checkOutput("arst_per_valid", int'(per_valid), 0);
    checkOutput("arst_locked",    int'(locked),    0);
    checkOutput("arst_err",       int'(err),       0);
    checkOutput("arst_timeout",   int'(timeout),   0);
    @(negedge clk);
    reset = 1'b0;
    lockOnThree("post_rst");

    // Silence: timeout exactly PMAX edges after the last event.
    for (int i = 0; i < PMAX - 1; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("pre_to_timeout", int'(timeout), 0);
    checkOutput("pre_to_locked",  int'(locked),  1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("to_strobe", int'(timeout), 1);
    checkOutput("to_locked", int'(locked),  0);
    checkOutput("to_period", int'(period),  3);
    applyStimulus(1'b0, 1'b1);
    checkOutput("to_once", int'(timeout), 0);

    // Longest legal spacing measures without a timeout.
    applyStimulus(1'b1, 1'b1);
    checkOutput("max_arm_pv", int'(per_valid), 0);
    pulseAfter(PMAX);
    checkOutput("max_period",  int'(period),    PMAX);
    checkOutput("max_pv",      int'(per_valid), 1);
    checkOutput("max_timeout", int'(timeout),   0);

    // pulse_in held high: period 1 after the second edge, lock after four more.
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("cont_period", int'(period),    1);
    checkOutput("cont_pv",     int'(per_valid), 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
    checkOutput("cont_pre_lock", int'(locked), 0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("cont_locked", int'(locked), 1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
